rv32i_ctrl_alu_dmem: RTL and testbench
======================================

Name: rv32i_ctrl_alu_dmem

Overview:
- Execute/memory slice of the single-cycle RV32I core.
- Combines three pieces:
  - the main control decoder (opcode/func3/func7 → datapath controls, branch resolution);
  - the 32-bit ALU;
  - a byte-enabled 4 KiB data RAM.
- The data RAM write port is owned by an external loader until `init_done` rises; after that, store traffic from the core drives it.
- PC, register file, sign-extend and store-lane steering sit outside this block.

Parameters:
- DATA_WIDTH, 32, datapath and memory word width.
- ADDR_WIDTH, 12, memory byte-address width (4 KiB).
- DEPTH, 1024, memory words.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous active-high reset.
- opcode  in  7  instr[6:0].
- func3  in  3  instr[14:12].
- func7  in  7  instr[31:25].
- rs1_dat  in  32  register operand 1.
- rs2_dat  in  32  register operand 2.
- imm  in  32  sign-extended immediate.
- st_dat  in  32  lane-steered store data.
- st_byte_enb  in  4  store byte enables.
- init_done  in  1  0: loader owns the write port; 1: core owns it.
- ld_w_addr  in  12  loader byte address.
- ld_w_dat  in  32  loader write data.
- ld_w_enb  in  1  loader write enable.
- ld_byte_enb  in  4  loader byte enables.
- debug_addr  in  12  debug read byte address.
- branch  out  1  take PC target.
- imm_src  out  3  immediate format.
- mem_read  out  1  data RAM read enable.
- mem_2_reg  out  1  load indicator.
- alu_ctrl  out  4  ALU operation.
- mem_write  out  1  store.
- alu_src  out  1  1: operand B = imm.
- reg_write  out  1  register-file write enable.
- wrt_back_src  out  2  write-back mux select.
- second_add_src  out  2  second-adder select.
- alu_result  out  32  ALU result.
- alu_zero  out  1  alu_result == 0.
- alu_last_bit  out  1  alu_result[0].
- mem_rdat  out  32  data RAM read word.
- debug_data  out  32  word at debug_addr[11:2].

Behaviour:
- One clock; reset synchronous, active-high.
- Control path, ALU and RAM reads are combinational; only RAM writes are clocked.
- While rst=1, all control outputs are 0 and `alu_ctrl`=ADD, so no write occurs at that edge. `alu_result`, `mem_rdat` and `debug_data` stay combinational.
- RAM contents are zero at time 0 and are not cleared by rst.
- Encodings (shared package):
  - alu_ctrl: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLL 5, SRL 6, SRA 7, SLT 8, SLTU 9.
  - imm_src: I 0, S 1, B 2, U 3, J 4.
  - wrt_back_src: MEM 0, ALU 1, PC+4 2, SEC 3.
  - second_add_src: NONE 0, LUI 1, AUIPC 2, JALR 3.
- Shifts use operand B[4:0]. SLT/SLTU produce 0 or 1.
- Decode:
  - R-type 0110011: func3/func7[5] select the op (SUB and SRA when func7[5]=1); reg_write=1, wb=ALU.
  - I-ALU 0010011: alu_src=1, imm_src=I. SRAI when func7[5]=1. SUB is never selected.
  - Load 0000011: ADD, alu_src=1, mem_read=1, mem_2_reg=1, reg_write=1, wb=MEM.
  - Store 0100011: ADD, alu_src=1, imm_src=S, mem_write=1, reg_write=0.
  - Branch 1100011: imm_src=B, sec=AUIPC.
    - BEQ/BNE use SUB, taken on zero / !zero.
    - BLT/BGE use SLT, taken on last_bit / !last_bit.
    - BLTU/BGEU use SLTU, taken on last_bit / !last_bit.
  - JAL 1101111: branch=1, imm_src=J, sec=AUIPC, reg_write=1, wb=PC+4.
  - JALR 1100111: branch=1, sec=JALR, reg_write=1, wb=PC+4.
  - LUI 0110111: imm_src=U, sec=LUI, reg_write=1, wb=SEC.
  - AUIPC 0010111: imm_src=U, sec=AUIPC, reg_write=1, wb=SEC.
  - Unknown opcodes: all controls 0.
- RAM read: `mem_rdat` = mem[alu_result[11:2]] when mem_read=1, else 0. Always a full word; sub-word extraction is done externally.
- RAM write, on the clk edge when rst=0:
  - Source: loader fields if init_done=0; otherwise {alu_result[11:2],00}, st_dat, mem_write and st_byte_enb.
  - Only bytes whose enable bit is set are updated; all other bytes are preserved.
  - Address bits above [11] are ignored, so addresses wrap at 4 KiB.
- Read-during-write to the same word returns the old word until the clock edge.

Decomposition:
- Package rv32i_ctrl_pkg holds: opcode constants, alu_ctrl / imm_src / wrt_back_src / second_add_src encodings, DATA_WIDTH.
- Sub-module dmem_be32 contains the byte-enabled RAM with its async read and debug read ports.
- The ALU and the decoder stay inline as combinational always blocks.

Test Plan:
- Reset behaviour: hold rst=1 with a store opcode and ld_w_enb=0 → mem_write=0, reg_write=0, branch=0; RAM unchanged.
- Loader then word load:
  - Loader writes 0x0000ABCD at 0x0, enb 1111; set init_done=1.
  - Issue LW with rs1=0, imm=0 → mem_rdat=0x0000ABCD, wrt_back_src=0, reg_write=1.
- Half-word stores:
  - SH with rs1=0x10, imm=0, st_dat=0x0000ABCD, st_byte_enb=0011 → debug_data(0x10)[15:0]=ABCD.
  - Then SH at 0x12, st_dat=0x12340000, enb 1100 → word reads 0x1234ABCD (low half preserved).
- R-type arithmetic:
  - SUB with 5−5 → alu_result=0, alu_zero=1.
  - SLT with −1 vs 1 → alu_result=1, alu_last_bit=1.
  - SRA of 0x80000000 by 4 → 0xF8000000.
- Branch resolution:
  - BEQ with rs1=rs2=7 → branch=1, second_add_src=2.
  - BNE with the same operands → branch=0.
  - BGEU with 1 vs 0xFFFFFFFF → branch=0.
- Write-back selects: LUI → wrt_back_src=3, second_add_src=1; JALR → branch=1, second_add_src=3, wrt_back_src=2.

Source files
------------

// File: rtl/rv32i_ctrl_pkg.sv
// Shared encodings for the RV32I execute/memory slice: opcodes, ALU operations,
// immediate formats and write-back / second-adder selects.
package rv32i_ctrl_pkg;

    localparam int DATA_WIDTH = 32;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_ctrl_e;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_src_e;

    typedef enum logic [1:0] {
        WB_MEM = 2'd0,
        WB_ALU = 2'd1,
        WB_PC4 = 2'd2,
        WB_SEC = 2'd3
    } wb_src_e;

    typedef enum logic [1:0] {
        SEC_NONE  = 2'd0,
        SEC_LUI   = 2'd1,
        SEC_AUIPC = 2'd2,
        SEC_JALR  = 2'd3
    } sec_src_e;

    // Register and immediate ALU ops share func3; only R-type may turn ADD into SUB.
    function automatic alu_ctrl_e alu_op_decode(input logic [2:0] f3, input logic alt,
                                                input logic allow_sub);
        alu_ctrl_e op;
        case (f3)
            3'b000:  op = (alt && allow_sub) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/dmem_be32.sv
// Byte-enabled word RAM with one clocked write port and two asynchronous
// read ports (datapath and debug). Contents power up as zero.
module dmem_be32
    import rv32i_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = rv32i_ctrl_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = 12,
    parameter int DEPTH      = 1024
) (
    input  logic                      clk_i,
    input  logic                      we_i,
    input  logic [ADDR_WIDTH-3:0]     waddr_i,
    input  logic [DATA_WIDTH-1:0]     wdat_i,
    input  logic [DATA_WIDTH/8-1:0]   be_i,
    input  logic [ADDR_WIDTH-3:0]     raddr_i,
    output logic [DATA_WIDTH-1:0]     rdat_o,
    input  logic [ADDR_WIDTH-3:0]     dbg_addr_i,
    output logic [DATA_WIDTH-1:0]     dbg_dat_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH] = '{default: '0};

    always_ff @(posedge clk_i) begin
        for (int b = 0; b < DATA_WIDTH/8; b++) begin
            if (we_i && be_i[b]) begin
                mem_q[waddr_i][8*b +: 8] <= wdat_i[8*b +: 8];
            end
        end
    end

    assign rdat_o    = mem_q[raddr_i];
    assign dbg_dat_o = mem_q[dbg_addr_i];

endmodule

// File: rtl/rv32i_ctrl_alu_dmem.sv
// Execute/memory slice of the single-cycle RV32I core: main decoder with
// branch resolution, 32-bit ALU and the byte-enabled data RAM.
module rv32i_ctrl_alu_dmem
    import rv32i_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = rv32i_ctrl_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = 12,
    parameter int DEPTH      = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              opcode,
    input  logic [2:0]              func3,
    input  logic [6:0]              func7,
    input  logic [DATA_WIDTH-1:0]   rs1_dat,
    input  logic [DATA_WIDTH-1:0]   rs2_dat,
    input  logic [DATA_WIDTH-1:0]   imm,
    input  logic [DATA_WIDTH-1:0]   st_dat,
    input  logic [DATA_WIDTH/8-1:0] st_byte_enb,
    input  logic                    init_done,
    input  logic [ADDR_WIDTH-1:0]   ld_w_addr,
    input  logic [DATA_WIDTH-1:0]   ld_w_dat,
    input  logic                    ld_w_enb,
    input  logic [DATA_WIDTH/8-1:0] ld_byte_enb,
    input  logic [ADDR_WIDTH-1:0]   debug_addr,
    output logic                    branch,
    output logic [2:0]              imm_src,
    output logic                    mem_read,
    output logic                    mem_2_reg,
    output logic [3:0]              alu_ctrl,
    output logic                    mem_write,
    output logic                    alu_src,
    output logic                    reg_write,
    output logic [1:0]              wrt_back_src,
    output logic [1:0]              second_add_src,
    output logic [DATA_WIDTH-1:0]   alu_result,
    output logic                    alu_zero,
    output logic                    alu_last_bit,
    output logic [DATA_WIDTH-1:0]   mem_rdat,
    output logic [DATA_WIDTH-1:0]   debug_data
);

    alu_ctrl_e             alu_op;
    imm_src_e              imm_sel;
    wb_src_e               wb_sel;
    sec_src_e              sec_sel;
    logic                  is_branch;
    logic                  is_jump;
    logic                  take_branch;
    logic [DATA_WIDTH-1:0] op_b;
    logic [4:0]            shamt;
    logic                  wr_en;
    logic [ADDR_WIDTH-3:0] wr_word;
    logic [DATA_WIDTH-1:0] wr_dat;
    logic [DATA_WIDTH/8-1:0] wr_be;
    logic [DATA_WIDTH-1:0] ram_word;
    logic                  unused_bits;

    // Reset forces every control low (ALU op = ADD) so nothing is written that edge.
    always_comb begin
        alu_op    = ALU_ADD;
        imm_sel   = IMM_I;
        wb_sel    = WB_MEM;
        sec_sel   = SEC_NONE;
        mem_read  = 1'b0;
        mem_2_reg = 1'b0;
        mem_write = 1'b0;
        alu_src   = 1'b0;
        reg_write = 1'b0;
        is_branch = 1'b0;
        is_jump   = 1'b0;
        if (!rst) begin
            case (opcode)
                OP_RTYPE: begin
                    alu_op    = alu_op_decode(func3, func7[5], 1'b1);
                    reg_write = 1'b1;
                    wb_sel    = WB_ALU;
                end
                OP_IALU: begin
                    alu_op    = alu_op_decode(func3, func7[5], 1'b0);
                    alu_src   = 1'b1;
                    reg_write = 1'b1;
                    wb_sel    = WB_ALU;
                end
                OP_LOAD: begin
                    alu_src   = 1'b1;
                    mem_read  = 1'b1;
                    mem_2_reg = 1'b1;
                    reg_write = 1'b1;
                    wb_sel    = WB_MEM;
                end
                OP_STORE: begin
                    alu_src   = 1'b1;
                    imm_sel   = IMM_S;
                    mem_write = 1'b1;
                end
                OP_BRANCH: begin
                    imm_sel   = IMM_B;
                    sec_sel   = SEC_AUIPC;
                    is_branch = 1'b1;
                    case (func3[2:1])
                        2'b00:   alu_op = ALU_SUB;
                        2'b10:   alu_op = ALU_SLT;
                        2'b11:   alu_op = ALU_SLTU;
                        default: alu_op = ALU_ADD;
                    endcase
                end
                OP_JAL: begin
                    is_jump   = 1'b1;
                    imm_sel   = IMM_J;
                    sec_sel   = SEC_AUIPC;
                    reg_write = 1'b1;
                    wb_sel    = WB_PC4;
                end
                OP_JALR: begin
                    is_jump   = 1'b1;
                    sec_sel   = SEC_JALR;
                    reg_write = 1'b1;
                    wb_sel    = WB_PC4;
                end
                OP_LUI: begin
                    imm_sel   = IMM_U;
                    sec_sel   = SEC_LUI;
                    reg_write = 1'b1;
                    wb_sel    = WB_SEC;
                end
                OP_AUIPC: begin
                    imm_sel   = IMM_U;
                    sec_sel   = SEC_AUIPC;
                    reg_write = 1'b1;
                    wb_sel    = WB_SEC;
                end
                default: ;
            endcase
        end
    end

    assign alu_ctrl       = alu_op;
    assign imm_src        = imm_sel;
    assign wrt_back_src   = wb_sel;
    assign second_add_src = sec_sel;

    assign op_b  = alu_src ? imm : rs2_dat;
    assign shamt = op_b[4:0];

    always_comb begin
        case (alu_op)
            ALU_ADD:  alu_result = rs1_dat + op_b;
            ALU_SUB:  alu_result = rs1_dat - op_b;
            ALU_AND:  alu_result = rs1_dat & op_b;
            ALU_OR:   alu_result = rs1_dat | op_b;
            ALU_XOR:  alu_result = rs1_dat ^ op_b;
            ALU_SLL:  alu_result = rs1_dat << shamt;
            ALU_SRL:  alu_result = rs1_dat >> shamt;
            ALU_SRA:  alu_result = $signed(rs1_dat) >>> shamt;
            ALU_SLT:  alu_result = {{(DATA_WIDTH-1){1'b0}}, $signed(rs1_dat) < $signed(op_b)};
            ALU_SLTU: alu_result = {{(DATA_WIDTH-1){1'b0}}, rs1_dat < op_b};
            default:  alu_result = '0;
        endcase
    end

    assign alu_zero     = (alu_result == '0);
    assign alu_last_bit = alu_result[0];

    // BEQ/BNE test the SUB result for zero; the ordered compares test the SLT(U) bit.
    always_comb begin
        take_branch = 1'b0;
        if (is_branch) begin
            case (func3)
                3'b000:  take_branch = alu_zero;
                3'b001:  take_branch = !alu_zero;
                3'b100:  take_branch = alu_last_bit;
                3'b101:  take_branch = !alu_last_bit;
                3'b110:  take_branch = alu_last_bit;
                3'b111:  take_branch = !alu_last_bit;
                default: take_branch = 1'b0;
            endcase
        end
    end

    assign branch = is_jump | take_branch;

    assign wr_en   = !rst && (init_done ? mem_write : ld_w_enb);
    assign wr_word = init_done ? alu_result[ADDR_WIDTH-1:2] : ld_w_addr[ADDR_WIDTH-1:2];
    assign wr_dat  = init_done ? st_dat : ld_w_dat;
    assign wr_be   = init_done ? st_byte_enb : ld_byte_enb;

    dmem_be32 #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_dmem (
        .clk_i      (clk),
        .we_i       (wr_en),
        .waddr_i    (wr_word),
        .wdat_i     (wr_dat),
        .be_i       (wr_be),
        .raddr_i    (alu_result[ADDR_WIDTH-1:2]),
        .rdat_o     (ram_word),
        .dbg_addr_i (debug_addr[ADDR_WIDTH-1:2]),
        .dbg_dat_o  (debug_data)
    );

    assign mem_rdat = mem_read ? ram_word : '0;

    assign unused_bits = ^{ld_w_addr[1:0], debug_addr[1:0], func7[6], func7[4:0]};

endmodule

// File: tb/tb_rv32i_ctrl_alu_dmem.sv
// Randomized self-checking bench for rv32i_ctrl_alu_dmem against an
// instruction-level reference model and a byte-array memory model.
module tb_rv32i_ctrl_alu_dmem;

    logic        clk;
    logic        rst;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [31:0] rs1_dat, rs2_dat, imm, st_dat;
    logic [3:0]  st_byte_enb;
    logic        init_done;
    logic [11:0] ld_w_addr;
    logic [31:0] ld_w_dat;
    logic        ld_w_enb;
    logic [3:0]  ld_byte_enb;
    logic [11:0] debug_addr;
    logic        branch, mem_read, mem_2_reg, mem_write, alu_src, reg_write;
    logic [2:0]  imm_src;
    logic [3:0]  alu_ctrl;
    logic [1:0]  wrt_back_src, second_add_src;
    logic [31:0] alu_result, mem_rdat, debug_data;
    logic        alu_zero, alu_last_bit;
    logic [16:0] dut_ctrl;

    int passed = 0;
    int total  = 0;
    logic [7:0] mb [4096];

    rv32i_ctrl_alu_dmem dut (
        .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .func7(func7),
        .rs1_dat(rs1_dat), .rs2_dat(rs2_dat), .imm(imm), .st_dat(st_dat),
        .st_byte_enb(st_byte_enb), .init_done(init_done), .ld_w_addr(ld_w_addr),
        .ld_w_dat(ld_w_dat), .ld_w_enb(ld_w_enb), .ld_byte_enb(ld_byte_enb),
        .debug_addr(debug_addr), .branch(branch), .imm_src(imm_src),
        .mem_read(mem_read), .mem_2_reg(mem_2_reg), .alu_ctrl(alu_ctrl),
        .mem_write(mem_write), .alu_src(alu_src), .reg_write(reg_write),
        .wrt_back_src(wrt_back_src), .second_add_src(second_add_src),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_last_bit(alu_last_bit),
        .mem_rdat(mem_rdat), .debug_data(debug_data)
    );

    assign dut_ctrl = {branch, imm_src, mem_read, mem_2_reg, alu_ctrl, mem_write,
                       alu_src, reg_write, wrt_back_src, second_add_src};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [3:0] ref_alu_code(input logic [2:0] f3, input logic alt,
                                                input logic is_r);
        case (f3)
            3'b000:  return (alt && is_r) ? 4'd1 : 4'd0;
            3'b001:  return 4'd5;
            3'b010:  return 4'd8;
            3'b011:  return 4'd9;
            3'b100:  return 4'd4;
            3'b101:  return alt ? 4'd7 : 4'd6;
            3'b110:  return 4'd3;
            default: return 4'd2;
        endcase
    endfunction

    function automatic logic [16:0] ref_ctrl(input logic [6:0] op, input logic [2:0] f3,
                                             input logic [6:0] f7, input logic [31:0] a,
                                             input logic [31:0] b);
        logic br, mr, m2r, mw, as, rw;
        logic [2:0] is;
        logic [3:0] ac;
        logic [1:0] wb, sc;
        {br, mr, m2r, mw, as, rw} = '0;
        is = 3'd0; ac = 4'd0; wb = 2'd0; sc = 2'd0;
        case (op)
            7'b0110011: begin ac = ref_alu_code(f3, f7[5], 1'b1); rw = 1; wb = 2'd1; end
            7'b0010011: begin ac = ref_alu_code(f3, f7[5], 1'b0); as = 1; rw = 1; wb = 2'd1; end
            7'b0000011: begin as = 1; mr = 1; m2r = 1; rw = 1; wb = 2'd0; end
            7'b0100011: begin as = 1; is = 3'd1; mw = 1; end
            7'b1100011: begin
                is = 3'd2; sc = 2'd2;
                case (f3)
                    3'b000: begin ac = 4'd1; br = (a == b); end
                    3'b001: begin ac = 4'd1; br = (a != b); end
                    3'b100: begin ac = 4'd8; br = ($signed(a) < $signed(b)); end
                    3'b101: begin ac = 4'd8; br = !($signed(a) < $signed(b)); end
                    3'b110: begin ac = 4'd9; br = (a < b); end
                    3'b111: begin ac = 4'd9; br = !(a < b); end
                    default: ;
                endcase
            end
            7'b1101111: begin br = 1; is = 3'd4; sc = 2'd2; rw = 1; wb = 2'd2; end
            7'b1100111: begin br = 1; sc = 2'd3; rw = 1; wb = 2'd2; end
            7'b0110111: begin is = 3'd3; sc = 2'd1; rw = 1; wb = 2'd3; end
            7'b0010111: begin is = 3'd3; sc = 2'd2; rw = 1; wb = 2'd3; end
            default: ;
        endcase
        return {br, is, mr, m2r, ac, mw, as, rw, wb, sc};
    endfunction

    // Result of an R-type or I-ALU instruction by its architectural meaning.
    function automatic logic [31:0] ref_arith(input logic [6:0] op, input logic [2:0] f3,
                                              input logic [6:0] f7, input logic [31:0] a,
                                              input logic [31:0] b, input logic [31:0] im);
        logic [31:0] y;
        int sh;
        y  = (op == 7'b0110011) ? b : im;
        sh = int'(y[4:0]);
        case (f3)
            3'b000:  return (op == 7'b0110011 && f7[5]) ? a - y : a + y;
            3'b001:  return a << sh;
            3'b010:  return ($signed(a) < $signed(y)) ? 32'd1 : 32'd0;
            3'b011:  return (a < y) ? 32'd1 : 32'd0;
            3'b100:  return a ^ y;
            3'b101:  return f7[5] ? 32'($signed(a) >>> sh) : a >> sh;
            3'b110:  return a | y;
            default: return a & y;
        endcase
    endfunction

    function automatic logic [31:0] model_word(input logic [11:0] addr);
        int base;
        base = int'(addr[11:2]) * 4;
        return {mb[base+3], mb[base+2], mb[base+1], mb[base]};
    endfunction

    task automatic model_write(input logic [11:0] addr, input logic [31:0] d,
                               input logic [3:0] be);
        int base;
        base = int'(addr[11:2]) * 4;
        for (int b = 0; b < 4; b++) if (be[b]) mb[base+b] = d[8*b +: 8];
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] im);
        opcode = op; func3 = f3; func7 = f7; rs1_dat = a; rs2_dat = b; imm = im;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        @(negedge clk);
        rst = 1; init_done = 1; ld_w_enb = 0;
        drive(7'b0100011, 3'b010, 7'd0, 32'h20, 32'h0, 32'h0);
        st_dat = 32'hFFFF_FFFF; st_byte_enb = 4'hF;
        #1;
        total++;
        if (dut_ctrl !== 17'd0) $display("FAIL rst_ctrl got=%h exp=%h", dut_ctrl, 17'd0);
        else passed++;
        total++;
        if (alu_result !== 32'h20) $display("FAIL rst_alu got=%h exp=%h", alu_result, 32'h20);
        else passed++;
        @(negedge clk);
        debug_addr = 12'h020;
        #1;
        total++;
        if (debug_data !== model_word(12'h020))
            $display("FAIL rst_nowrite got=%h exp=%h", debug_data, model_word(12'h020));
        else passed++;
        @(negedge clk);
        rst = 0; init_done = 0; st_byte_enb = 0;
        drive(7'd0, 3'd0, 7'd0, 32'd0, 32'd0, 32'd0);
    endtask

    task automatic test_loader_load();
        logic [11:0] addrs [16];
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            addrs[i]    = 12'($urandom);
            ld_w_addr   = addrs[i];
            ld_w_dat    = $urandom;
            ld_byte_enb = 4'($urandom);
            ld_w_enb    = 1;
            model_write(ld_w_addr, ld_w_dat, ld_byte_enb);
        end
        @(negedge clk);
        ld_w_addr = 12'h000; ld_w_dat = 32'h0000_ABCD; ld_byte_enb = 4'hF; ld_w_enb = 1;
        model_write(12'h000, 32'h0000_ABCD, 4'hF);
        @(negedge clk);
        ld_w_enb = 0;
        for (int i = 0; i < 16; i++) begin
            debug_addr = addrs[i];
            #1;
            total++;
            if (debug_data !== model_word(addrs[i]))
                $display("FAIL loader_word addr=%h got=%h exp=%h", addrs[i], debug_data,
                         model_word(addrs[i]));
            else passed++;
        end
        // Core owns the port now: a stray loader strobe must be ignored.
        @(negedge clk);
        init_done = 1;
        ld_w_enb = 1; ld_w_addr = 12'h000; ld_w_dat = 32'hFFFF_FFFF; ld_byte_enb = 4'hF;
        drive(7'b0000011, 3'b010, 7'd0, 32'd0, 32'd0, 32'd0);
        #1;
        total++;
        if (mem_rdat !== 32'h0000_ABCD) $display("FAIL lw_rdat got=%h exp=%h", mem_rdat, 32'h0000ABCD);
        else passed++;
        total++;
        if (wrt_back_src !== 2'd0 || reg_write !== 1'b1)
            $display("FAIL lw_wb got=%0d/%0d exp=0/1", wrt_back_src, reg_write);
        else passed++;
        total++;
        if (dut_ctrl !== ref_ctrl(7'b0000011, 3'b010, 7'd0, 32'd0, 32'd0))
            $display("FAIL lw_ctrl got=%h exp=%h", dut_ctrl, ref_ctrl(7'b0000011, 3'b010, 7'd0, 32'd0, 32'd0));
        else passed++;
        @(negedge clk);
        ld_w_enb = 0;
        debug_addr = 12'h000;
        #1;
        total++;
        if (debug_data !== 32'h0000_ABCD) $display("FAIL loader_ignored got=%h exp=%h", debug_data, 32'h0000ABCD);
        else passed++;
    endtask

    task automatic test_half_stores();
        @(negedge clk);
        drive(7'b0100011, 3'b001, 7'd0, 32'h10, 32'd0, 32'd0);
        st_dat = 32'h0000_ABCD; st_byte_enb = 4'b0011;
        #1;
        total++;
        if (mem_write !== 1'b1 || reg_write !== 1'b0 || mem_rdat !== 32'd0)
            $display("FAIL sh_ctrl got=%b%b rdat=%h exp=10 rdat=0", mem_write, reg_write, mem_rdat);
        else passed++;
        model_write(12'h010, st_dat, st_byte_enb);
        @(negedge clk);
        debug_addr = 12'h010;
        drive(7'b0100011, 3'b001, 7'd0, 32'h12, 32'd0, 32'd0);
        st_dat = 32'h1234_0000; st_byte_enb = 4'b1100;
        #1;
        total++;
        if (debug_data[15:0] !== 16'hABCD) $display("FAIL sh_low got=%h exp=%h", debug_data[15:0], 16'hABCD);
        else passed++;
        model_write(12'h012, st_dat, st_byte_enb);
        @(negedge clk);
        st_byte_enb = 0;
        drive(7'd0, 3'd0, 7'd0, 32'd0, 32'd0, 32'd0);
        #1;
        total++;
        if (debug_data !== 32'h1234_ABCD) $display("FAIL sh_high got=%h exp=%h", debug_data, 32'h1234ABCD);
        else passed++;
    endtask

    task automatic test_alu();
        logic [6:0]  op, f7;
        logic [2:0]  f3;
        logic [31:0] a, b, im, exp_r;
        @(negedge clk);
        drive(7'b0110011, 3'b000, 7'h20, 32'd5, 32'd5, 32'd0);
        #1;
        total++;
        if (alu_result !== 32'd0 || alu_zero !== 1'b1)
            $display("FAIL sub_zero got=%h z=%b exp=0 z=1", alu_result, alu_zero);
        else passed++;
        drive(7'b0110011, 3'b010, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'd0);
        #1;
        total++;
        if (alu_result !== 32'd1 || alu_last_bit !== 1'b1)
            $display("FAIL slt_neg got=%h lb=%b exp=1 lb=1", alu_result, alu_last_bit);
        else passed++;
        drive(7'b0110011, 3'b101, 7'h20, 32'h8000_0000, 32'd4, 32'd0);
        #1;
        total++;
        if (alu_result !== 32'hF800_0000) $display("FAIL sra got=%h exp=%h", alu_result, 32'hF8000000);
        else passed++;
        for (int i = 0; i < 60; i++) begin
            op = ($urandom_range(0, 1) == 0) ? 7'b0110011 : 7'b0010011;
            f3 = 3'($urandom);
            f7 = ($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20;
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
            im = ($urandom_range(0, 1) == 0) ? 32'($signed(12'($urandom))) : a;
            drive(op, f3, f7, a, b, im);
            #1;
            exp_r = ref_arith(op, f3, f7, a, b, im);
            total++;
            if (alu_result !== exp_r || alu_zero !== (exp_r == 0) || alu_last_bit !== exp_r[0])
                $display("FAIL alu_rand op=%h f3=%0d f7=%h a=%h b=%h imm=%h got=%h exp=%h",
                         op, f3, f7, a, b, im, alu_result, exp_r);
            else passed++;
            total++;
            if (dut_ctrl !== ref_ctrl(op, f3, f7, a, b))
                $display("FAIL alu_ctrl_rand op=%h f3=%0d got=%h exp=%h", op, f3, dut_ctrl,
                         ref_ctrl(op, f3, f7, a, b));
            else passed++;
        end
    endtask

    task automatic test_branches();
        logic [2:0]  f3;
        logic [31:0] a, b;
        logic [2:0]  f3s [6];
        f3s = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};
        @(negedge clk);
        drive(7'b1100011, 3'b000, 7'd0, 32'd7, 32'd7, 32'd0);
        #1;
        total++;
        if (branch !== 1'b1 || second_add_src !== 2'd2)
            $display("FAIL beq got=%b/%0d exp=1/2", branch, second_add_src);
        else passed++;
        func3 = 3'b001;
        #1;
        total++;
        if (branch !== 1'b0) $display("FAIL bne got=%b exp=0", branch);
        else passed++;
        drive(7'b1100011, 3'b111, 7'd0, 32'd1, 32'hFFFF_FFFF, 32'd0);
        #1;
        total++;
        if (branch !== 1'b0) $display("FAIL bgeu got=%b exp=0", branch);
        else passed++;
        for (int i = 0; i < 40; i++) begin
            f3 = f3s[$urandom_range(0, 5)];
            a  = $urandom;
            case ($urandom_range(0, 2))
                0:       b = a;
                1:       b = a ^ 32'h8000_0000;
                default: b = $urandom;
            endcase
            drive(7'b1100011, f3, 7'($urandom), a, b, $urandom);
            #1;
            total++;
            if (dut_ctrl !== ref_ctrl(7'b1100011, f3, func7, a, b))
                $display("FAIL br_rand f3=%0d a=%h b=%h got=%h exp=%h", f3, a, b, dut_ctrl,
                         ref_ctrl(7'b1100011, f3, func7, a, b));
            else passed++;
        end
    endtask

    task automatic test_wb_selects();
        logic [6:0] ops [5];
        ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1111111};
        @(negedge clk);
        drive(7'b0110111, 3'd0, 7'd0, 32'd0, 32'd0, 32'h1234_5000);
        #1;
        total++;
        if (wrt_back_src !== 2'd3 || second_add_src !== 2'd1)
            $display("FAIL lui got=%0d/%0d exp=3/1", wrt_back_src, second_add_src);
        else passed++;
        drive(7'b1100111, 3'd0, 7'd0, 32'h100, 32'd0, 32'h4);
        #1;
        total++;
        if (branch !== 1'b1 || second_add_src !== 2'd3 || wrt_back_src !== 2'd2)
            $display("FAIL jalr got=%b/%0d/%0d exp=1/3/2", branch, second_add_src, wrt_back_src);
        else passed++;
        for (int i = 0; i < 5; i++) begin
            drive(ops[i], 3'($urandom), 7'($urandom), $urandom, $urandom, $urandom);
            #1;
            total++;
            if (dut_ctrl !== ref_ctrl(ops[i], func3, func7, rs1_dat, rs2_dat))
                $display("FAIL wb_ctrl op=%h got=%h exp=%h", ops[i], dut_ctrl,
                         ref_ctrl(ops[i], func3, func7, rs1_dat, rs2_dat));
            else passed++;
        end
    endtask

    task automatic test_back_to_back_mem();
        logic [31:0] a, im;
        logic [11:0] ad;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            a  = $urandom;
            im = 32'($signed(12'($urandom)));
            ad = 12'(a + im);
            drive(7'b0100011, 3'($urandom_range(0, 2)), 7'd0, a, 32'd0, im);
            st_dat = $urandom; st_byte_enb = 4'($urandom_range(1, 15));
            debug_addr = ad;
            #1;
            total++;
            if (debug_data !== model_word(ad))
                $display("FAIL rdw_old addr=%h got=%h exp=%h", ad, debug_data, model_word(ad));
            else passed++;
            model_write(ad, st_dat, st_byte_enb);
            @(negedge clk);
            st_byte_enb = 0;
            drive(7'b0000011, 3'b010, 7'd0, a, 32'd0, im);
            #1;
            total++;
            if (mem_rdat !== model_word(ad))
                $display("FAIL st_ld addr=%h got=%h exp=%h", ad, mem_rdat, model_word(ad));
            else passed++;
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mb[i] = 8'h00;
        rst = 1; init_done = 0; ld_w_enb = 0; ld_w_addr = 0; ld_w_dat = 0; ld_byte_enb = 0;
        st_dat = 0; st_byte_enb = 0; debug_addr = 0;
        drive(7'd0, 3'd0, 7'd0, 32'd0, 32'd0, 32'd0);
        test_reset();
        test_loader_load();
        test_half_stores();
        test_alu();
        test_branches();
        test_wb_selects();
        test_back_to_back_mem();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
